// File: rtl/vga_console.sv
// vga_console: byte-stream text terminal front end for the VGA character pipeline.
// Keeps a cursor, interprets CR/LF/BS/FF (and TAB when enabled), wraps lines and
// erases the whole screen or a single row by sweeping space writes, one per cycle.
//
// Optional feature: define VGA_CONSOLE_TAB_EN to make 0x09 advance to the next tab stop.
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   in_valid/in_data  byte offered; accepted when in_valid & in_ready
//   in_ready          high only in the idle state
//   vga_char_wr       registered one-cycle cell write strobe
//   vga_char_in/x/y   registered character code and target cell
//   cursor_x/y        current cursor position
//   busy              clear sweep in progress
module vga_console #(
   parameter int unsigned COLS      = 80,
   parameter int unsigned ROWS      = 30,
   parameter int unsigned TAB_WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       vga_char_wr,
   output logic [7:0] vga_char_in,
   output logic [6:0] vga_char_x,
   output logic [4:0] vga_char_y,
   output logic [6:0] cursor_x,
   output logic [4:0] cursor_y,
   output logic       busy
);

   typedef enum logic [1:0] {StIdle, StClrAll, StClrRow} state_e;

   localparam logic [6:0] LastX = 7'(COLS - 1);
   localparam logic [4:0] LastY = 5'(ROWS - 1);

   state_e     state_q, state_d;
   logic [6:0] sx_q, sx_d;   // sweep column
   logic [4:0] sy_q, sy_d;   // sweep row (full-screen sweep only)
   logic [6:0] cx_q, cx_d;
   logic [4:0] cy_q, cy_d;
   logic       wr_q, wr_d;
   logic [7:0] ch_q, ch_d;
   logic [6:0] wx_q, wx_d;
   logic [4:0] wy_q, wy_d;
   logic [4:0] next_row;

`ifdef VGA_CONSOLE_TAB_EN
   logic [7:0] tab_next;
   // Next multiple of TAB_WIDTH strictly above x; 8 bits so overflow past COLS is visible.
   assign tab_next = ({1'b0, cx_q} | 8'(TAB_WIDTH - 1)) + 8'd1;
`endif

   assign next_row = (cy_q == LastY) ? 5'd0 : cy_q + 5'd1;

   always_comb begin
      state_d = state_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      wr_d    = 1'b0;
      ch_d    = ch_q;
      wx_d    = wx_q;
      wy_d    = wy_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               if (in_data >= 8'h20) begin
                  wr_d = 1'b1;
                  ch_d = in_data;
                  wx_d = cx_q;
                  wy_d = cy_q;
                  if (cx_q < LastX) begin
                     cx_d = cx_q + 7'd1;
                  end else begin
                     cx_d    = 7'd0;
                     cy_d    = next_row;
                     sx_d    = 7'd0;
                     state_d = StClrRow;
                  end
               end else begin
                  case (in_data)
                     8'h0A: begin
                        cx_d    = 7'd0;
                        cy_d    = next_row;
                        sx_d    = 7'd0;
                        state_d = StClrRow;
                     end
                     8'h0D: cx_d = 7'd0;
                     8'h08: begin
                        // No reverse wrap at column 0.
                        if (cx_q != 7'd0) begin
                           cx_d = cx_q - 7'd1;
                           wr_d = 1'b1;
                           ch_d = 8'h20;
                           wx_d = cx_q - 7'd1;
                           wy_d = cy_q;
                        end
                     end
                     8'h0C: begin
                        sx_d    = 7'd0;
                        sy_d    = 5'd0;
                        state_d = StClrAll;
                     end
`ifdef VGA_CONSOLE_TAB_EN
                     8'h09: begin
                        if (tab_next >= 8'(COLS)) begin
                           cx_d    = 7'd0;
                           cy_d    = next_row;
                           sx_d    = 7'd0;
                           state_d = StClrRow;
                        end else begin
                           cx_d = tab_next[6:0];
                        end
                     end
`endif
                     default: ;
                  endcase
               end
            end
         end
         StClrAll: begin
            wr_d = 1'b1;
            ch_d = 8'h20;
            wx_d = sx_q;
            wy_d = sy_q;
            if (sx_q == LastX) begin
               sx_d = 7'd0;
               if (sy_q == LastY) begin
                  sy_d    = 5'd0;
                  cx_d    = 7'd0;
                  cy_d    = 5'd0;
                  state_d = StIdle;
               end else begin
                  sy_d = sy_q + 5'd1;
               end
            end else begin
               sx_d = sx_q + 7'd1;
            end
         end
         StClrRow: begin
            wr_d = 1'b1;
            ch_d = 8'h20;
            wx_d = sx_q;
            wy_d = cy_q;
            if (sx_q == LastX) begin
               sx_d    = 7'd0;
               state_d = StIdle;
            end else begin
               sx_d = sx_q + 7'd1;
            end
         end
         default: state_d = StClrAll;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StClrAll;
         sx_q    <= 7'd0;
         sy_q    <= 5'd0;
         cx_q    <= 7'd0;
         cy_q    <= 5'd0;
         wr_q    <= 1'b0;
         ch_q    <= 8'h00;
         wx_q    <= 7'd0;
         wy_q    <= 5'd0;
      end else begin
         state_q <= state_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         wr_q    <= wr_d;
         ch_q    <= ch_d;
         wx_q    <= wx_d;
         wy_q    <= wy_d;
      end
   end

   // in_ready is decoded from state so it rises alongside the final sweep write.
   assign in_ready    = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign vga_char_wr = wr_q;
   assign vga_char_in = ch_q;
   assign vga_char_x  = wx_q;
   assign vga_char_y  = wy_q;
   assign cursor_x    = cx_q;
   assign cursor_y    = cy_q;

endmodule

// File: tb/tb_vga_console.sv
// Directed self-checking bench for vga_console (80x30, tab width 8).
module tb_vga_console;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       vga_char_wr;
   logic [7:0] vga_char_in;
   logic [6:0] vga_char_x;
   logic [4:0] vga_char_y;
   logic [6:0] cursor_x;
   logic [4:0] cursor_y;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   vga_console #(.COLS(80), .ROWS(30), .TAB_WIDTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .vga_char_wr(vga_char_wr),
      .vga_char_in(vga_char_in),
      .vga_char_x (vga_char_x),
      .vga_char_y (vga_char_y),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .busy       (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Offer one byte at a negedge; returns at the next negedge, after the accepting edge.
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic send_n(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) send(b);
   endtask

   // Watch a clear sweep until in_ready rises; n_exp writes over n_exp cycles expected.
   task automatic sweep(input string tag, input int n_exp, input int fy, input int ly);
      int cnt = 0;
      int iters = 0;
      int nonspace = 0;
      int fx_o = -1, fy_o = -1, lx_o = -1, ly_o = -1;
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         iters++;
         if (vga_char_wr) begin
            if (cnt == 0) begin
               fx_o = int'(vga_char_x);
               fy_o = int'(vga_char_y);
            end
            lx_o = int'(vga_char_x);
            ly_o = int'(vga_char_y);
            cnt++;
            if (vga_char_in != 8'h20) nonspace++;
         end
         if (in_ready) done = 1'b1;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " writes"}, cnt, n_exp);
      check({tag, " cycles"}, iters, n_exp);
      check({tag, " nonspace"}, nonspace, 0);
      check({tag, " first_x"}, fx_o, 0);
      check({tag, " first_y"}, fy_o, fy);
      check({tag, " last_x"}, lx_o, 79);
      check({tag, " last_y"}, ly_o, ly);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (2) @(negedge clk);
      check("rst wr", 32'(vga_char_wr), 0);
      check("rst ch", 32'(vga_char_in), 0);
      check("rst wx", 32'(vga_char_x), 0);
      check("rst wy", 32'(vga_char_y), 0);
      check("rst cx", 32'(cursor_x), 0);
      check("rst cy", 32'(cursor_y), 0);
      check("rst ready", 32'(in_ready), 0);
      check("rst busy", 32'(busy), 1);
      reset = 1'b0;
      sweep("boot", 2400, 0, 29);
      check("boot cx", 32'(cursor_x), 0);
      check("boot cy", 32'(cursor_y), 0);

      // Back-to-back printables.
      in_valid = 1'b1;
      in_data  = 8'h41;
      @(negedge clk);
      check("A wr", 32'(vga_char_wr), 1);
      check("A ch", 32'(vga_char_in), 32'h41);
      check("A x", 32'(vga_char_x), 0);
      check("A y", 32'(vga_char_y), 0);
      in_data = 8'h42;
      @(negedge clk);
      in_valid = 1'b0;
      check("B wr", 32'(vga_char_wr), 1);
      check("B ch", 32'(vga_char_in), 32'h42);
      check("B x", 32'(vga_char_x), 1);
      check("B y", 32'(vga_char_y), 0);
      check("AB cx", 32'(cursor_x), 2);
      check("AB cy", 32'(cursor_y), 0);

      // CR, then three LFs with row clears down to row 3.
      send(8'h0D);
      check("cr cx", 32'(cursor_x), 0);
      for (int r = 1; r <= 3; r++) begin
         send(8'h0A);
         check("lf ready", 32'(in_ready), 0);
         check("lf wr", 32'(vga_char_wr), 0);
         check("lf cy", 32'(cursor_y), 32'(r));
         sweep("lf row", 80, r, r);
      end

      // Backspace at (5,3), CR, then backspace at column 0.
      send_n(8'h61, 5);
      check("pre bs cx", 32'(cursor_x), 5);
      send(8'h08);
      check("bs wr", 32'(vga_char_wr), 1);
      check("bs ch", 32'(vga_char_in), 32'h20);
      check("bs x", 32'(vga_char_x), 4);
      check("bs y", 32'(vga_char_y), 3);
      check("bs cx", 32'(cursor_x), 4);
      check("bs cy", 32'(cursor_y), 3);
      send(8'h0D);
      check("cr2 wr", 32'(vga_char_wr), 0);
      check("cr2 cx", 32'(cursor_x), 0);
      check("cr2 cy", 32'(cursor_y), 3);
      send(8'h08);
      check("bs0 wr", 32'(vga_char_wr), 0);
      check("bs0 cx", 32'(cursor_x), 0);
      check("bs0 cy", 32'(cursor_y), 3);

      // Tab from (3,3).
      send_n(8'h61, 3);
      send(8'h09);
      check("tab wr", 32'(vga_char_wr), 0);
      check("tab cy", 32'(cursor_y), 3);
`ifdef VGA_CONSOLE_TAB_EN
      check("tab cx", 32'(cursor_x), 8);
      check("tab ready", 32'(in_ready), 1);
      send_n(8'h61, 69);
      check("pre tab2 cx", 32'(cursor_x), 77);
      send(8'h09);
      check("tab2 wr", 32'(vga_char_wr), 0);
      check("tab2 ready", 32'(in_ready), 0);
      check("tab2 cx", 32'(cursor_x), 0);
      check("tab2 cy", 32'(cursor_y), 4);
      sweep("tab2 row", 80, 4, 4);
`else
      check("tab cx", 32'(cursor_x), 3);
      check("tab ready", 32'(in_ready), 1);
`endif

      // Form feed: full clear, cursor home.
      send(8'h0C);
      check("ff wr", 32'(vga_char_wr), 0);
      check("ff ready", 32'(in_ready), 0);
      check("ff busy", 32'(busy), 1);
      sweep("ff", 2400, 0, 29);
      check("ff cx", 32'(cursor_x), 0);
      check("ff cy", 32'(cursor_y), 0);

      // Walk to (79,29).
      for (int r = 1; r <= 29; r++) begin
         send(8'h0A);
         sweep("walk row", 80, r, r);
      end
      send_n(8'h62, 79);
      check("walk cx", 32'(cursor_x), 79);
      check("walk cy", 32'(cursor_y), 29);

      // Printable at the last cell wraps to row 0 and clears it.
      send(8'h5A);
      check("Z wr", 32'(vga_char_wr), 1);
      check("Z ch", 32'(vga_char_in), 32'h5A);
      check("Z x", 32'(vga_char_x), 79);
      check("Z y", 32'(vga_char_y), 29);
      check("Z ready", 32'(in_ready), 0);
      check("Z cx", 32'(cursor_x), 0);
      check("Z cy", 32'(cursor_y), 0);
      sweep("Z row", 80, 0, 0);

      // Reset in the middle of a form-feed sweep.
      send(8'h51);
      check("Q cx", 32'(cursor_x), 1);
      send(8'h0C);
      repeat (1200) @(negedge clk);
      check("mid wr", 32'(vga_char_wr), 1);
      reset = 1'b1;
      #1;
      check("mid rst wr", 32'(vga_char_wr), 0);
      check("mid rst ch", 32'(vga_char_in), 0);
      check("mid rst wx", 32'(vga_char_x), 0);
      check("mid rst wy", 32'(vga_char_y), 0);
      check("mid rst cx", 32'(cursor_x), 0);
      check("mid rst cy", 32'(cursor_y), 0);
      check("mid rst ready", 32'(in_ready), 0);
      check("mid rst busy", 32'(busy), 1);
      @(negedge clk);
      reset = 1'b0;
      sweep("reboot", 2400, 0, 29);
      check("reboot cx", 32'(cursor_x), 0);
      check("reboot cy", 32'(cursor_y), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
